// File: rtl/region_bounds.sv
// rtl/region_bounds.sv - per-frame bounding box and hit count of class-masked pixels
module region_bounds #(
  parameter int N = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  class_mask,
  input  logic          in_write,
  input  logic [N-1:0]  in_data,
  input  logic [11:0]   in_x,
  input  logic [11:0]   in_y,
  input  logic          in_done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_found,
  output logic [11:0]   out_min_x,
  output logic [11:0]   out_max_x,
  output logic [11:0]   out_min_y,
  output logic [11:0]   out_max_y,
  output logic [23:0]   out_count,
  output logic          out_overrun
);

  typedef enum logic {IDLE, PUBLISH} state_t;

  state_t state, state_next;
  logic done_prev;
  logic eof, hit;

  logic [11:0] acc_min_x, acc_max_x, acc_min_y, acc_max_y;
  logic [23:0] acc_count;
  logic        acc_found;

  logic [11:0] base_min_x, base_max_x, base_min_y, base_max_y;
  logic [23:0] base_count;
  logic        base_found;

  assign eof = in_done & ~done_prev;
  assign hit = in_write & (|(in_data & class_mask));

  // A hit coinciding with EOF lands on the freshly initialised accumulators.
  always_comb begin
    base_min_x = acc_min_x;
    base_max_x = acc_max_x;
    base_min_y = acc_min_y;
    base_max_y = acc_max_y;
    base_count = acc_count;
    base_found = acc_found;
    if (eof) begin
      base_min_x = 12'hFFF;
      base_max_x = 12'h000;
      base_min_y = 12'hFFF;
      base_max_y = 12'h000;
      base_count = 24'd0;
      base_found = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_min_x <= 12'hFFF;
      acc_max_x <= 12'h000;
      acc_min_y <= 12'hFFF;
      acc_max_y <= 12'h000;
      acc_count <= 24'd0;
      acc_found <= 1'b0;
    end else begin
      acc_min_x <= (hit && in_x < base_min_x) ? in_x : base_min_x;
      acc_max_x <= (hit && in_x > base_max_x) ? in_x : base_max_x;
      acc_min_y <= (hit && in_y < base_min_y) ? in_y : base_min_y;
      acc_max_y <= (hit && in_y > base_max_y) ? in_y : base_max_y;
      acc_count <= (hit && base_count != 24'hFFFFFF) ? base_count + 24'd1 : base_count;
      acc_found <= base_found | hit;
    end
  end

  // Result registers; an empty frame reports zero bounds rather than the init values.
  always_ff @(posedge clock) begin
    if (reset) begin
      done_prev   <= 1'b1;
      out_found   <= 1'b0;
      out_min_x   <= 12'h000;
      out_max_x   <= 12'h000;
      out_min_y   <= 12'h000;
      out_max_y   <= 12'h000;
      out_count   <= 24'd0;
      out_overrun <= 1'b0;
    end else begin
      done_prev <= in_done;
      if (eof) begin
        out_found <= acc_found;
        out_min_x <= acc_found ? acc_min_x : 12'h000;
        out_max_x <= acc_found ? acc_max_x : 12'h000;
        out_min_y <= acc_found ? acc_min_y : 12'h000;
        out_max_y <= acc_found ? acc_max_y : 12'h000;
        out_count <= acc_found ? acc_count : 24'd0;
        if (state == PUBLISH && !out_ready)
          out_overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (eof)
          state_next = PUBLISH;
      end
      PUBLISH: begin
        out_valid = 1'b1;
        if (!eof && out_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_region_bounds.sv
// tb/tb_region_bounds.sv - scoreboard bench for region_bounds with a frame-list reference model
module tb_region_bounds;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  class_mask;
  logic        in_write;
  logic [2:0]  in_data;
  logic [11:0] in_x, in_y;
  logic        in_done;
  logic        out_valid, out_ready, out_found, out_overrun;
  logic [11:0] out_min_x, out_max_x, out_min_y, out_max_y;
  logic [23:0] out_count;

  always #5 clock = ~clock;

  region_bounds #(.N(3)) dut (
    .clock(clock), .reset(reset), .class_mask(class_mask),
    .in_write(in_write), .in_data(in_data), .in_x(in_x), .in_y(in_y),
    .in_done(in_done), .out_valid(out_valid), .out_ready(out_ready),
    .out_found(out_found), .out_min_x(out_min_x), .out_max_x(out_max_x),
    .out_min_y(out_min_y), .out_max_y(out_max_y), .out_count(out_count),
    .out_overrun(out_overrun)
  );

  typedef struct {
    logic        found;
    logic [11:0] min_x, max_x, min_y, max_y;
    logic [23:0] count;
  } res_t;

  int tests = 0;
  int fails = 0;

  res_t        q[$];
  logic [23:0] frame[$];
  logic        prev_done = 1'b1;
  logic        ovr_now = 1'b0;
  logic        mon_en = 1'b0;

  logic stage_clear, stage_push, stage_replace;
  res_t stage_res;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t summarize();
    res_t r;
    r.found = frame.size() > 0;
    r.count = 24'(frame.size());
    r.min_x = 0; r.max_x = 0; r.min_y = 0; r.max_y = 0;
    if (r.found) begin
      r.min_x = frame[0][23:12]; r.max_x = frame[0][23:12];
      r.min_y = frame[0][11:0];  r.max_y = frame[0][11:0];
      foreach (frame[i]) begin
        if (frame[i][23:12] < r.min_x) r.min_x = frame[i][23:12];
        if (frame[i][23:12] > r.max_x) r.max_x = frame[i][23:12];
        if (frame[i][11:0]  < r.min_y) r.min_y = frame[i][11:0];
        if (frame[i][11:0]  > r.max_y) r.max_y = frame[i][11:0];
      end
    end
    return r;
  endfunction

  // Model one cycle of the current inputs, advance the clock, then expose the new expectations.
  task automatic step();
    logic eof;
    stage_clear = 0; stage_push = 0; stage_replace = 0;
    if (reset) begin
      stage_clear = 1;
      frame.delete();
      prev_done = 1'b1;
    end else begin
      eof = in_done && !prev_done;
      prev_done = in_done;
      if (eof) begin
        stage_res = summarize();
        frame.delete();
        stage_push = 1;
        stage_replace = (q.size() > 0) && !out_ready;
      end
      if (in_write && (in_data & class_mask) != 3'b000)
        frame.push_back({in_x, in_y});
    end
    @(posedge clock);
    #1;
    if (stage_clear) begin
      q.delete();
      ovr_now = 1'b0;
    end else if (stage_push) begin
      if (stage_replace && q.size() > 0) begin
        q[q.size()-1] = stage_res;
        ovr_now = 1'b1;
      end else begin
        q.push_back(stage_res);
      end
    end
  endtask

  task automatic pixel(input int x, input int y, input logic [2:0] d);
    in_write = 1; in_x = 12'(x); in_y = 12'(y); in_data = d;
    step();
    in_write = 0;
  endtask

  task automatic eof_pulse();
    in_done = 1; step();
    in_done = 0; step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("out_overrun", 32'(out_overrun), 32'(ovr_now));
      if (out_valid && q.size() > 0) begin
        chk("out_found", 32'(out_found), 32'(q[0].found));
        chk("out_min_x", 32'(out_min_x), 32'(q[0].min_x));
        chk("out_max_x", 32'(out_max_x), 32'(q[0].max_x));
        chk("out_min_y", 32'(out_min_y), 32'(q[0].min_y));
        chk("out_max_y", 32'(out_max_y), 32'(q[0].max_y));
        chk("out_count", 32'(out_count), 32'(q[0].count));
        if (out_ready && !reset) void'(q.pop_front());
      end
    end
  end

  initial begin
    reset = 1; class_mask = 3'b001; in_write = 0; in_data = 0;
    in_x = 0; in_y = 0; in_done = 0; out_ready = 1;
    step(); step();
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_found", 32'(out_found), 0);
    chk("reset_count", 32'(out_count), 0);
    chk("reset_bounds", {out_min_x, out_max_x, out_min_y, out_max_y} == 48'd0 ? 1 : 0, 1);
    chk("reset_overrun", 32'(out_overrun), 0);
    reset = 0;
    mon_en = 1;

    // 4x2 frame with hits at (1,0),(3,1),(2,1); in_done held high for a few cycles
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 4; x++)
        pixel(x, y, ((x == 1 && y == 0) || (x == 3 && y == 1) || (x == 2 && y == 1)) ? 3'b001 : 3'b010);
    in_done = 1; idle(4);
    in_done = 0; idle(2);

    // frame without hits
    pixel(4, 4, 3'b110); pixel(5, 4, 3'b000);
    eof_pulse(); idle(2);

    // consumer stalls for 5 cycles after publish
    out_ready = 0;
    pixel(10, 20, 3'b011);
    eof_pulse(); idle(5);
    out_ready = 1; idle(2);

    // two EOFs without accept -> overrun, second frame single hit at (7,5)
    out_ready = 0;
    pixel(1, 1, 3'b001); pixel(30, 2, 3'b001);
    eof_pulse();
    pixel(7, 5, 3'b001);
    eof_pulse(); idle(2);
    out_ready = 1; idle(2);

    // hit at (0,0) coincides with EOF and belongs to the next frame
    pixel(5, 5, 3'b001);
    in_write = 1; in_x = 0; in_y = 0; in_data = 3'b001; in_done = 1;
    step();
    in_write = 0; in_done = 0; step();
    pixel(9, 9, 3'b001);
    eof_pulse(); idle(2);

    // reset mid-frame with in_done held high across it
    for (int i = 0; i < 10; i++) pixel(100 + i, 50 + i, 3'b001);
    in_done = 1; reset = 1; step(); step();
    reset = 0; idle(3);
    in_done = 0; step();
    pixel(3, 4, 3'b001); pixel(6, 2, 3'b001);
    eof_pulse(); idle(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 63) == 0) class_mask = 3'($urandom);
      in_write = $urandom_range(0, 2) != 0;
      in_data = 3'($urandom);
      in_x = ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom);
      in_y = ($urandom_range(0, 9) == 0) ? 12'h000 : 12'($urandom);
      if ($urandom_range(0, 11) == 0) in_done = ~in_done;
      out_ready = $urandom_range(0, 2) != 0;
      step();
    end
    reset = 0; in_write = 0; out_ready = 1; idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/region_bounds.md
REGION_BOUNDS -- requirements
Module: region_bounds

Interface
REQ-001 Parameter N, default 3: pixel data width, matching the upstream pixel counter stage.
REQ-002 clock  in  1  single clock; all logic is rising-edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 class_mask  in  N  selects which pixel data bits count as a hit; sampled every cycle.
REQ-005 in_write  in  1  pixel strobe from the upstream pixel counter stage.
REQ-006 in_data  in  N  pixel class bits, valid when in_write=1.
REQ-007 in_x  in  12  column of the current pixel, valid when in_write=1.
REQ-008 in_y  in  12  row of the current pixel, valid when in_write=1.
REQ-009 in_done  in  1  frame-complete level from the upstream stage.
REQ-010 out_valid  out  1  result available.
REQ-011 out_ready  in  1  consumer accepts the result.
REQ-012 out_found  out  1  at least one hit pixel was seen in the frame.
REQ-013 out_min_x, out_max_x, out_min_y, out_max_y  out  12 each  bounding box of the hit pixels.
REQ-014 out_count  out  24  number of hit pixels.
REQ-015 out_overrun  out  1  sticky flag: an unaccepted result was overwritten.

Function
REQ-016 Hit definition: in_write=1 and (in_data AND class_mask) is nonzero.
REQ-017 Per-frame accumulators:
- acc_min_x/acc_min_y initialise to 12'hFFF; acc_max_x/acc_max_y initialise to 0.
- acc_count initialises to 0; acc_found initialises to 0.
REQ-018 On a hit, the accumulators update on the next edge:
- min becomes the smaller of the current value and in_x/in_y.
- max becomes the larger of the current value and in_x/in_y.
- acc_count increments by 1; acc_found is set.
REQ-019 acc_count saturates at 24'hFFFFFF; it never wraps.
REQ-020 End of frame (EOF) is the rising edge of in_done (in_done=1 while the previous-cycle in_done=0); a held-high in_done produces one EOF only.
REQ-021 On EOF, the block publishes in one cycle:
- the accumulators are copied to the out_* result registers;
- out_valid=1 on the next cycle;
- the accumulators reinitialise per REQ-017.
REQ-022 Empty frame (acc_found=0) at EOF publishes out_found=0, out_count=0 and all bounds 0, not the initialisation values.
REQ-023 A hit in the same cycle as EOF belongs to the new frame: it is applied to the freshly initialised accumulators.
REQ-024 State machine has two states:
- IDLE (out_valid=0) goes to PUBLISH on EOF.
- PUBLISH (out_valid=1) goes to IDLE on out_valid AND out_ready with no EOF in that cycle.
REQ-025 Accumulation continues in both states; the handshake never stalls the input, and there is no backpressure upstream.
REQ-026 While out_valid=1 and out_ready=0, all out_* result fields are held stable.
REQ-027 EOF in PUBLISH:
- without acceptance in the same cycle, the result is overwritten, out_overrun is set and the state stays PUBLISH;
- with acceptance in the same cycle, the old result counts as consumed, the new result loads and the state stays PUBLISH, with no overrun.
REQ-028 out_overrun clears only on reset.
REQ-029 Latency: out_valid rises exactly 1 cycle after the EOF cycle.

Reset
REQ-030 reset=1 takes priority over every other input.
REQ-031 Reset values:
- out_valid, out_found, out_count, all out bounds and out_overrun are 0;
- the state is IDLE;
- the accumulators take their REQ-017 values;
- the in_done history register is 1, so a level already high is not an EOF.
REQ-032 Reset mid-frame discards the partial accumulation and any pending result; no EOF is generated for that frame.

Verification
REQ-033 4x2 frame, mask=3'b001, hits at (1,0),(3,1),(2,1); in_done rises -> one cycle later: out_valid=1, found=1, min_x=1, max_x=3, min_y=0, max_y=1, count=3.
REQ-034 Frame with no hits -> out_valid=1, found=0, count=0, all bounds 0.
REQ-035 out_ready=0 for 5 cycles after publish, then 1 -> fields stable throughout; out_valid drops the cycle after the accept.
REQ-036 Two EOFs with no accept between them, second frame single hit at (7,5) -> out_overrun=1; outputs show min=max=(7,5), count=1.
REQ-037 Hit at (0,0) in the same cycle as EOF -> the published frame excludes it; the next frame reports min_x=0, min_y=0, count>=1.
REQ-038 reset asserted mid-frame after 10 hits, then a clean frame with 2 hits -> published count=2; in_done held high across reset yields no EOF.
